// File: rtl/spi_mem_ctrl.sv
// spi_mem_ctrl: decodes SPI command frames and round-robin shares one memory port with a host port
module spi_mem_ctrl #(
    parameter int ADDR_WIDTH  = 8,
    parameter int MEM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [9:0]            rx_data,
    input  logic                  rx_valid,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  host_req,
    input  logic                  host_we,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [7:0]            host_wdata,
    output logic                  host_gnt,
    output logic [7:0]            host_rdata,
    output logic                  host_rvalid,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    input  logic [7:0]            mem_rdata,
    output logic                  busy,
    output logic                  err_ovr
);
    typedef enum logic [1:0] {ARB_IDLE, ACCESS, RD_WAIT} arb_state_t;

    arb_state_t state, state_nx;
    logic       rx_prev, rx_rise;
    logic [1:0] cmd;
    logic [7:0] payload;
    logic [7:0] wr_addr, rd_addr;
    logic       spi_pend, spi_we;
    logic [7:0] spi_addr, spi_wdata;
    logic       spi_clr, spi_req, spi_accept;
    logic       last_host, gnt_host;
    logic       grant_spi, grant_host;
    logic [2:0] lat_cnt;
    logic       rd_done;

    assign cmd        = rx_data[9:8];
    assign payload    = rx_data[7:0];
    assign rx_rise    = rx_valid & ~rx_prev;
    assign spi_clr    = (state == ACCESS) & ~gnt_host;
    assign spi_req    = rx_rise & cmd[0];
    assign spi_accept = spi_req & (~spi_pend | spi_clr);
    assign grant_spi  = (state == ARB_IDLE) & spi_pend & (~host_req | last_host);
    assign grant_host = (state == ARB_IDLE) & host_req & ~grant_spi;
    assign rd_done    = (state == RD_WAIT) & (lat_cnt == 3'(MEM_LATENCY));

    // Arbiter state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ARB_IDLE;
        else        state <= state_nx;
    end

    // Arbiter next state and access strobes
    always_comb begin
        state_nx = state;
        mem_en   = 1'b0;
        host_gnt = 1'b0;
        busy     = state != ARB_IDLE;
        case (state)
            ARB_IDLE: state_nx = (grant_spi | grant_host) ? ACCESS : ARB_IDLE;
            ACCESS: begin
                mem_en   = 1'b1;
                host_gnt = gnt_host;
                state_nx = mem_we ? ARB_IDLE : RD_WAIT;
            end
            RD_WAIT: state_nx = rd_done ? ARB_IDLE : RD_WAIT;
            default: state_nx = ARB_IDLE;
        endcase
    end

    // Frame decode: address loads, single pending SPI request, sticky overrun flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_prev   <= 1'b0;
            wr_addr   <= '0;
            rd_addr   <= '0;
            spi_pend  <= 1'b0;
            spi_we    <= 1'b0;
            spi_addr  <= '0;
            spi_wdata <= '0;
            err_ovr   <= 1'b0;
        end else begin
            rx_prev <= rx_valid;
            if (rx_rise && cmd == 2'b00) wr_addr <= payload;
            if (rx_rise && cmd == 2'b10) rd_addr <= payload;
            if (spi_accept) begin
                spi_pend <= 1'b1;
                spi_we   <= ~cmd[1];
                spi_addr <= cmd[1] ? rd_addr : wr_addr;
                if (!cmd[1]) spi_wdata <= payload;
            end else if (spi_clr) begin
                spi_pend <= 1'b0;
            end
            if (spi_req && !spi_accept) err_ovr <= 1'b1;
        end
    end

    // Grant bookkeeping and memory command registers, held between accesses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_host <= 1'b1;
            gnt_host  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            lat_cnt   <= 3'd1;
        end else begin
            if (grant_spi || grant_host) begin
                last_host <= grant_host;
                gnt_host  <= grant_host;
                mem_we    <= grant_spi ? spi_we : host_we;
                mem_addr  <= grant_spi ? ADDR_WIDTH'(spi_addr) : host_addr;
                mem_wdata <= grant_spi ? spi_wdata : host_wdata;
            end
            lat_cnt <= (state == RD_WAIT) ? lat_cnt + 3'd1 : 3'd1;
        end
    end

    // Read returns: SPI data held until the next frame, host data as a pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data     <= '0;
            tx_valid    <= 1'b0;
            host_rdata  <= '0;
            host_rvalid <= 1'b0;
        end else begin
            host_rvalid <= rd_done & gnt_host;
            if (rd_done && gnt_host) host_rdata <= mem_rdata;
            if (rd_done && !gnt_host) begin
                tx_data  <= mem_rdata;
                tx_valid <= 1'b1;
            end else if (rx_rise) begin
                tx_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_spi_mem_ctrl.sv
// tb_spi_mem_ctrl: vector table, random ops against a memory model, and hand-timed corner sequences
module tb_spi_mem_ctrl;
    logic       clk = 0, rst_n = 0;
    logic [9:0] rx_data = '0;
    logic       rx_valid = 0;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       host_req = 0, host_we = 0;
    logic [7:0] host_addr = '0, host_wdata = '0;
    logic       host_gnt, host_rvalid;
    logic [7:0] host_rdata;
    logic       mem_en, mem_we;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic       busy, err_ovr;

    spi_mem_ctrl #(.ADDR_WIDTH(8), .MEM_LATENCY(1)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .host_req(host_req), .host_we(host_we),
        .host_addr(host_addr), .host_wdata(host_wdata), .host_gnt(host_gnt),
        .host_rdata(host_rdata), .host_rvalid(host_rvalid), .mem_en(mem_en),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .err_ovr(err_ovr)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [256];
    logic [7:0] rd_pipe = '0;
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        rd_pipe <= mem[mem_addr];
        end
    end
    assign mem_rdata = rd_pipe;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {logic we; logic [7:0] addr; logic [7:0] wdata; int cyc;} acc_t;
    acc_t acc_q[$];
    always @(negedge clk) if (mem_en === 1'b1) acc_q.push_back('{mem_we, mem_addr, mem_wdata, cyc});

    typedef struct {logic host; logic we; logic [7:0] addr; logic [7:0] data; logic [7:0] exp;} vec_t;
    vec_t tbl [8];

    logic [7:0] ref_mem [256];
    bit         ref_valid [256];
    int n_pass = 0, n_total = 0;
    logic [7:0] rd, hrd;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic frame(input logic [1:0] c, input logic [7:0] p, input int hold);
        rx_data  = {c, p};
        rx_valid = 1;
        repeat (hold) @(negedge clk);
        rx_valid = 0;
        @(negedge clk);
    endtask

    task automatic wait_tx(output logic [7:0] r);
        logic ok = 0;
        r = '0;
        for (int i = 0; i < 30 && !ok; i++) begin
            if (tx_valid) begin ok = 1; r = tx_data; end
            else @(negedge clk);
        end
        check("tx_valid_seen", ok, 1);
    endtask

    task automatic host_access(input logic we, input logic [7:0] a, input logic [7:0] d, output logic [7:0] r);
        logic ok = 0;
        r = '0;
        host_req = 1; host_we = we; host_addr = a; host_wdata = d;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clk);
            ok = host_gnt;
        end
        check("host_gnt_seen", ok, 1);
        host_req = 0;
        if (!we) begin
            ok = 0;
            for (int i = 0; i < 30 && !ok; i++) begin
                @(negedge clk);
                if (host_rvalid) begin ok = 1; r = host_rdata; end
            end
            check("host_rvalid_seen", ok, 1);
        end
    endtask

    task automatic do_op(input logic host, input logic we, input logic [7:0] a, input logic [7:0] d, output logic [7:0] r);
        acc_q.delete();
        r = '0;
        if (host) host_access(we, a, d, r);
        else if (we) begin frame(2'b00, a, 1); frame(2'b01, d, 1); end
        else begin frame(2'b10, a, 1); frame(2'b11, 8'h00, 1); wait_tx(r); end
        repeat (4) @(negedge clk);
        check("op_count", acc_q.size(), 1);
        if (acc_q.size() > 0) begin
            check("op_we", acc_q[0].we, we);
            check("op_addr", acc_q[0].addr, a);
            if (we) check("op_wdata", acc_q[0].wdata, d);
        end
        if (we) begin ref_mem[a] = d; ref_valid[a] = 1; end
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        int c0, first_hi, nw;
        logic h, w;
        logic [7:0] a, d;
        tbl[0] = '{1'b1, 1'b1, 8'h05, 8'h11, 8'h00};
        tbl[1] = '{1'b0, 1'b1, 8'h06, 8'h22, 8'h00};
        tbl[2] = '{1'b0, 1'b0, 8'h05, 8'h00, 8'h11};
        tbl[3] = '{1'b1, 1'b0, 8'h06, 8'h00, 8'h22};
        tbl[4] = '{1'b0, 1'b1, 8'h05, 8'h99, 8'h00};
        tbl[5] = '{1'b1, 1'b0, 8'h05, 8'h00, 8'h99};
        tbl[6] = '{1'b0, 1'b0, 8'h06, 8'h00, 8'h22};
        tbl[7] = '{1'b1, 1'b1, 8'h06, 8'hC3, 8'h00};

        repeat (3) @(negedge clk);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_host_gnt", host_gnt, 0);
        check("rst_host_rvalid", host_rvalid, 0);
        check("rst_host_rdata", host_rdata, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_err_ovr", err_ovr, 0);
        rst_n = 1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            do_op(tbl[i].host, tbl[i].we, tbl[i].addr, tbl[i].data, rd);
            if (!tbl[i].we) check($sformatf("vec%0d_rdata", i), rd, tbl[i].exp);
        end

        for (int i = 0; i < 40; i++) begin
            h = 1'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            a = 8'($urandom_range(0, 15));
            d = 8'($urandom);
            if (!ref_valid[a]) w = 1;
            do_op(h, w, a, d, rd);
            if (!w) check($sformatf("rand%0d_rdata", i), rd, ref_mem[a]);
        end

        // SPI write, latency of mem_en from the frame edge
        acc_q.delete();
        frame(2'b00, 8'h12, 1);
        repeat (12) @(negedge clk);
        c0 = cyc;
        frame(2'b01, 8'hA5, 1);
        repeat (12) @(negedge clk);
        check("t1_count", acc_q.size(), 1);
        if (acc_q.size() > 0) begin
            check("t1_we", acc_q[0].we, 1);
            check("t1_addr", acc_q[0].addr, 8'h12);
            check("t1_wdata", acc_q[0].wdata, 8'hA5);
            check("t1_mem_en_cycle", acc_q[0].cyc - c0, 2);
        end

        // SPI read latency, hold and clear of tx_valid
        frame(2'b10, 8'h12, 1);
        acc_q.delete();
        c0 = cyc;
        frame(2'b11, 8'h00, 1);
        first_hi = -1;
        for (int i = 0; i < 20; i++) begin
            if (tx_valid && first_hi < 0) first_hi = cyc;
            @(negedge clk);
        end
        check("t2_tx_valid_latency", first_hi - c0, 4);
        check("t2_tx_data", tx_data, 8'hA5);
        check("t2_tx_valid_held", tx_valid, 1);
        if (acc_q.size() > 0) check("t2_rd_addr", acc_q[0].addr, 8'h12);
        frame(2'b00, 8'h01, 1);
        check("t2_tx_valid_cleared", tx_valid, 0);

        // Tie with last grant = host: SPI first
        do_op(1'b1, 1'b1, 8'h30, 8'h3C, rd);
        frame(2'b00, 8'h40, 1);
        repeat (2) @(negedge clk);
        acc_q.delete();
        fork
            frame(2'b01, 8'h77, 1);
            begin @(negedge clk); host_access(1'b0, 8'h30, 8'h00, hrd); end
        join
        repeat (4) @(negedge clk);
        check("t3a_count", acc_q.size(), 2);
        if (acc_q.size() > 1) begin
            check("t3a_first_is_spi_write", acc_q[0].we, 1);
            check("t3a_first_addr", acc_q[0].addr, 8'h40);
            check("t3a_second_is_host_read", acc_q[1].we, 0);
            check("t3a_second_addr", acc_q[1].addr, 8'h30);
        end
        check("t3a_host_rdata", hrd, 8'h3C);

        // Tie with last grant = SPI: host first
        frame(2'b01, 8'h78, 1);
        repeat (3) @(negedge clk);
        acc_q.delete();
        fork
            frame(2'b01, 8'h79, 1);
            begin @(negedge clk); host_access(1'b0, 8'h30, 8'h00, hrd); end
        join
        repeat (6) @(negedge clk);
        check("t3b_count", acc_q.size(), 2);
        if (acc_q.size() > 1) begin
            check("t3b_first_is_host_read", acc_q[0].we, 0);
            check("t3b_second_is_spi_write", acc_q[1].we, 1);
            check("t3b_second_wdata", acc_q[1].wdata, 8'h79);
        end
        check("t3b_host_rdata", hrd, 8'h3C);

        // Held rx_valid is one frame
        acc_q.delete();
        frame(2'b01, 8'h55, 5);
        repeat (6) @(negedge clk);
        check("t4_count", acc_q.size(), 1);
        if (acc_q.size() > 0) check("t4_wdata", acc_q[0].wdata, 8'h55);

        // Second SPI write while the first is still pending is dropped
        check("t5_err_before", err_ovr, 0);
        acc_q.delete();
        fork
            host_access(1'b0, 8'h30, 8'h00, hrd);
            begin @(negedge clk); frame(2'b01, 8'h11, 1); frame(2'b01, 8'h22, 1); end
        join
        repeat (6) @(negedge clk);
        nw = 0;
        foreach (acc_q[i]) if (acc_q[i].we) begin
            nw++;
            check("t5_write_wdata", acc_q[i].wdata, 8'h11);
        end
        check("t5_write_count", nw, 1);
        check("t5_access_count", acc_q.size(), 2);
        check("t5_err_ovr", err_ovr, 1);

        // Reset during RD_WAIT of a host read
        host_req = 1; host_we = 0; host_addr = 8'h30;
        @(negedge clk);
        check("t6_host_gnt", host_gnt, 1);
        host_req = 0;
        @(negedge clk);
        check("t6_busy_before", busy, 1);
        rst_n = 0;
        #1;
        check("t6_mem_en", mem_en, 0);
        check("t6_tx_valid", tx_valid, 0);
        check("t6_busy", busy, 0);
        check("t6_err_ovr", err_ovr, 0);
        @(negedge clk);
        rst_n = 1;
        nw = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (host_rvalid) nw++;
        end
        check("t6_no_rvalid", nw, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
